quad_core_sched: RTL and testbench
==================================

Name: quad_core_sched

Overview:
- Job scheduler in front of the four-lane quad_core FPU.
- Accepts operand sets (a,b,c,d) one per handshake and packs up to four of them into a batch, one job per lane.
- Drives the shared enable for the batch, waits for every active lane's finish flag, then streams the results out in arrival order.
- Sits between the host/issue logic and quad_core; it is the only driver of quad_core inputs.

Parameters:
- FILL_TIMEOUT, 16: idle cycles in FILL with ≥1 job collected before a partial batch is launched (range 1..255).
- WD_CYCLES, 1024: watchdog limit in BUSY, in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  job offered
- in_ready  out  1  scheduler accepts job
- in_a  in  32  operand a
- in_b  in  32  operand b
- in_c  in  32  operand c
- in_d  in  32  operand d
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_g  out  32  result word
- out_lane  out  2  lane that produced the result
- out_err  out  1  result is invalid (watchdog abort)
- busy  out  1  state is not IDLE
- core_en  out  1  to quad_core en
- core_a  out  128  lane operands a, packed {lane3,lane2,lane1,lane0}; likewise core_b, core_c, core_d (128 each)
- core_g  in  128  lane results, packed as above
- core_fi  in  4  lane finish flags {fi3,fi2,fi1,fi0}

Behaviour:
- Clocking and reset: single clock domain, all state on posedge clk; rst is synchronous, active-high.
- Reset values:
  - All outputs are 0 except in_ready = 1.
  - State = IDLE; fill count, active mask, timers and read pointer are 0.
  - Operand registers are cleared.
- Reset mid-batch abandons the batch: core_en drops on the next edge and no results are emitted.
- Job acceptance:
  - A job is accepted on an edge where in_valid && in_ready.
  - Job k of a batch (k = 0..3) is written to lane k's operand registers, and bit k of the active mask is set.
  - in_ready = 1 only in IDLE and FILL.
- States:
  - IDLE:
    - On accept, go to FILL with count = 1.
  - FILL:
    - Each accept increments count.
    - The idle timer resets on every accept and increments on every cycle with no accept.
    - The accept that brings count to 4 moves to START on the same edge.
    - If the idle timer reaches FILL_TIMEOUT, go to START with a partial batch.
    - Unused lanes have their operands held at 0 and are not in the active mask.
  - START:
    - One cycle with core_en = 1; go to BUSY.
  - BUSY:
    - core_en stays 1 and operands stay stable.
    - Each core_fi[k] is sampled into a done bit (sticky).
    - When done & mask == mask, latch core_g into the result registers, drop core_en, and go to DRAIN.
    - Latency from START to first out_valid is at least 2 cycles (START, then the BUSY cycle that sees fi, then DRAIN).
  - DRAIN:
    - out_valid = 1.
    - out_lane = read pointer; out_g = latched result for that lane; out_err = 0.
    - On out_ready, advance to the next set mask bit.
    - After the last active lane is taken, clear mask/done/count and go to IDLE, so core_en is low for at least 1 cycle between batches.
    - out_valid holds with stable data while out_ready = 0.
- Ordering: results leave in lane order 0→3, which equals arrival order.
- Finish flags: core_fi bits for inactive lanes, or outside BUSY, are ignored.
- Boundary: core_fi already high on the first BUSY cycle is a legal completion.

Optional Feature:
- Macro: QSCHED_WATCHDOG_EN.
- Defined:
  - A BUSY cycle counter resets on entry to BUSY.
  - If it reaches WD_CYCLES before all active lanes finish, move to DRAIN.
  - Lanes already done emit their result with out_err = 0.
  - Unfinished active lanes emit out_g = 0 and out_err = 1.
- Undefined:
  - No counter exists; BUSY waits indefinitely.
  - out_err is tied to 0.

Test Plan:
- Full batch: 4 back-to-back jobs with a = 1.0, 2.0, 3.0, 4.0 → core_en rises the cycle after the 4th accept; in_ready is 0 until drain completes; core_fi = 4'hF after 5 cycles gives 4 results with out_lane 0,1,2,3 carrying core_g lanes in order.
- Partial batch: 2 jobs then idle, FILL_TIMEOUT = 16 → START 16 cycles after the 2nd accept; mask = 4'b0011; core_a[127:64] = 0; exactly 2 results.
- Staggered finish: fi0 at +3, fi2 at +7, fi1 at +9, fi3 at +12 (pulses) → results latched only after fi3; all 4 correct.
- Backpressure: out_ready low for 10 cycles in DRAIN → out_valid, out_g and out_lane stay stable; no results lost or duplicated.
- Reset in BUSY: rst pulsed mid-batch → the next cycle shows core_en = 0, out_valid = 0, in_ready = 1; a new batch then completes normally.
- Watchdog (QSCHED_WATCHDOG_EN, WD_CYCLES = 8): fi3 never asserts → after 8 BUSY cycles, lanes 0–2 are output with out_err = 0 and lane 3 with out_g = 0, out_err = 1.

Source files
------------

// File: rtl/quad_core_sched.sv
// quad_core_sched: batches up to four jobs onto the four quad_core lanes,
// runs the batch with a shared enable, and streams the lane results out
// in arrival (lane) order.
// Optional feature macro: QSCHED_WATCHDOG_EN adds a BUSY watchdog that
// aborts a stuck batch after WD_CYCLES and flags unfinished lanes via out_err.

module quad_core_sched #(
    parameter int FILL_TIMEOUT = 16,
    parameter int WD_CYCLES    = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_a,
    input  logic [31:0]  in_b,
    input  logic [31:0]  in_c,
    input  logic [31:0]  in_d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_g,
    output logic [1:0]   out_lane,
    output logic         out_err,
    output logic         busy,
    output logic         core_en,
    output logic [127:0] core_a,
    output logic [127:0] core_b,
    output logic [127:0] core_c,
    output logic [127:0] core_d,
    input  logic [127:0] core_g,
    input  logic [3:0]   core_fi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_START,
        S_BUSY,
        S_DRAIN
    } state_e;

    state_e           state_q;
    logic [2:0]       count_q;
    logic [3:0]       mask_q;
    logic [3:0]       done_q;
    logic [7:0]       idle_q;
    logic [1:0]       rptr_q;
    logic [3:0][31:0] a_q;
    logic [3:0][31:0] b_q;
    logic [3:0][31:0] c_q;
    logic [3:0][31:0] d_q;
    logic [3:0][31:0] res_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             core_en_q;

    logic             accept;
    logic [1:0]       wr_lane;
    logic [3:0]       done_d;
    logic             all_done;
    logic             idle_expire;
    logic             next_found;
    logic [1:0]       next_lane;

    // Out-of-range parameters elaborate this marker block, making a bad
    // configuration visible in the hierarchy.
    if (FILL_TIMEOUT < 1 || FILL_TIMEOUT > 255 || WD_CYCLES < 1) begin : g_bad_params
    end

`ifdef QSCHED_WATCHDOG_EN
    logic [31:0]      wd_q;
    logic [3:0]       err_q;
    logic             wd_expire;

    assign wd_expire = (wd_q + 32'd1) >= 32'(WD_CYCLES);
`endif

    assign accept      = in_valid && in_ready_q;
    assign wr_lane     = (state_q == S_FILL) ? count_q[1:0] : 2'd0;
    assign done_d      = done_q | (core_fi & mask_q);
    assign all_done    = (done_d & mask_q) == mask_q;
    assign idle_expire = ({1'b0, idle_q} + 9'd1) >= 9'(FILL_TIMEOUT);

    // Find the next active lane above the read pointer, lowest first.
    always_comb begin
        next_found = 1'b0;
        next_lane  = rptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(rptr_q))) begin
                next_found = 1'b1;
                next_lane  = 2'(i);
            end
        end
    end

    // Scheduler FSM with all datapath registers and registered handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= 3'd0;
            mask_q      <= 4'd0;
            done_q      <= 4'd0;
            idle_q      <= 8'd0;
            rptr_q      <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            core_en_q   <= 1'b0;
`ifdef QSCHED_WATCHDOG_EN
            wd_q        <= 32'd0;
            err_q       <= 4'd0;
`endif
        end else begin
            if (accept) begin
                a_q[wr_lane]    <= in_a;
                b_q[wr_lane]    <= in_b;
                c_q[wr_lane]    <= in_c;
                d_q[wr_lane]    <= in_d;
                mask_q[wr_lane] <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= S_FILL;
                        count_q <= 3'd1;
                        idle_q  <= 8'd0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        count_q <= count_q + 3'd1;
                        idle_q  <= 8'd0;
                        if (count_q == 3'd3) begin
                            state_q    <= S_START;
                            in_ready_q <= 1'b0;
                            core_en_q  <= 1'b1;
                        end
                    end else if (idle_expire) begin
                        state_q    <= S_START;
                        in_ready_q <= 1'b0;
                        core_en_q  <= 1'b1;
                        idle_q     <= 8'd0;
                    end else begin
                        idle_q <= idle_q + 8'd1;
                    end
                end
                S_START: begin
                    state_q <= S_BUSY;
                    done_q  <= 4'd0;
`ifdef QSCHED_WATCHDOG_EN
                    wd_q    <= 32'd0;
`endif
                end
                S_BUSY: begin
                    done_q <= done_d;
                    if (all_done) begin
                        res_q       <= core_g;
                        core_en_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        rptr_q      <= 2'd0;
                        state_q     <= S_DRAIN;
`ifdef QSCHED_WATCHDOG_EN
                        err_q       <= 4'd0;
`endif
                    end
`ifdef QSCHED_WATCHDOG_EN
                    else if (wd_expire) begin
                        for (int i = 0; i < 4; i++) begin
                            res_q[i] <= done_d[i] ? core_g[32*i +: 32] : 32'd0;
                        end
                        err_q       <= mask_q & ~done_d;
                        core_en_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        rptr_q      <= 2'd0;
                        state_q     <= S_DRAIN;
                    end else begin
                        wd_q <= wd_q + 32'd1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (next_found) begin
                            rptr_q <= next_lane;
                        end else begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            mask_q      <= 4'd0;
                            done_q      <= 4'd0;
                            count_q     <= 3'd0;
                            rptr_q      <= 2'd0;
                            a_q         <= '0;
                            b_q         <= '0;
                            c_q         <= '0;
                            d_q         <= '0;
`ifdef QSCHED_WATCHDOG_EN
                            err_q       <= 4'd0;
`endif
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign core_en   = core_en_q;
    assign busy      = (state_q != S_IDLE);
    assign out_lane  = rptr_q;
    assign out_g     = res_q[rptr_q];
    assign core_a    = a_q;
    assign core_b    = b_q;
    assign core_c    = c_q;
    assign core_d    = d_q;

`ifdef QSCHED_WATCHDOG_EN
    assign out_err = err_q[rptr_q];
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_quad_core_sched.sv
// Directed self-checking bench for quad_core_sched: a table of batches plus
// hand-written staggered-finish, backpressure, reset-in-BUSY and watchdog
// sequences.

module tb_quad_core_sched;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_a;
    logic [31:0]  in_b;
    logic [31:0]  in_c;
    logic [31:0]  in_d;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_g;
    logic [1:0]   out_lane;
    logic         out_err;
    logic         busy;
    logic         core_en;
    logic [127:0] core_a;
    logic [127:0] core_b;
    logic [127:0] core_c;
    logic [127:0] core_d;
    logic [127:0] core_g;
    logic [3:0]   core_fi;

    int checkCount;
    int errorCount;

    typedef struct {
        int               nJobs;
        int               fiDelay;
        int               expWait;
        logic [3:0]       fiMask;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [3:0][31:0] c;
        logic [3:0][31:0] d;
        logic [3:0][31:0] g;
    } batchVec_t;

    batchVec_t vecs[4];

    quad_core_sched #(
        .FILL_TIMEOUT(16),
        .WD_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_c(in_c),
        .in_d(in_d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_g(out_g),
        .out_lane(out_lane),
        .out_err(out_err),
        .busy(busy),
        .core_en(core_en),
        .core_a(core_a),
        .core_b(core_b),
        .core_c(core_c),
        .core_d(core_d),
        .core_g(core_g),
        .core_fi(core_fi)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a sequence hangs.
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Offer the first n jobs of a vector back-to-back.
    task automatic applyStimulus(input batchVec_t v);
        for (int k = 0; k < v.nJobs; k++) begin
            in_valid = 1'b1;
            in_a = v.a[k];
            in_b = v.b[k];
            in_c = v.c[k];
            in_d = v.d[k];
            checkOutput("in_ready_fill", 128'(in_ready), 128'(1'b1));
            tick();
        end
        in_valid = 1'b0;
        in_a = 32'd0;
        in_b = 32'd0;
        in_c = 32'd0;
        in_d = 32'd0;
    endtask

    // Consume n results, optionally stalling 10 cycles on one lane.
    task automatic drainExpect(input int n, input logic [3:0][31:0] g, input logic [3:0] errMask, input int stallLane);
        for (int k = 0; k < n; k++) begin
            checkOutput("out_valid", 128'(out_valid), 128'(1'b1));
            checkOutput("out_lane", 128'(out_lane), 128'(k));
            checkOutput("out_g", 128'(out_g), 128'(g[k]));
            checkOutput("out_err", 128'(out_err), 128'(errMask[k]));
            checkOutput("in_ready_drain", 128'(in_ready), 128'(1'b0));
            if (k == stallLane) begin
                out_ready = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    tick();
                    checkOutput("stall_hold", 128'({out_valid, out_lane, out_g}), 128'({1'b1, 2'(k), g[k]}));
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        checkOutput("out_valid_after_drain", 128'(out_valid), 128'(1'b0));
        checkOutput("in_ready_after_drain", 128'(in_ready), 128'(1'b1));
        checkOutput("busy_after_drain", 128'(busy), 128'(1'b0));
        checkOutput("core_en_after_drain", 128'(core_en), 128'(1'b0));
    endtask

    // Full table-driven batch: send, launch, finish, drain.
    task automatic runBatch(input int idx);
        batchVec_t v;
        int waited;
        v = vecs[idx];
        applyStimulus(v);
        waited = 0;
        while (core_en !== 1'b1 && waited < 64) begin
            tick();
            waited++;
        end
        checkOutput("launch_delay", 128'(waited), 128'(v.expWait));
        checkOutput("in_ready_start", 128'(in_ready), 128'(1'b0));
        checkOutput("core_a", core_a, 128'(v.a));
        checkOutput("core_b", core_b, 128'(v.b));
        checkOutput("core_c", core_c, 128'(v.c));
        checkOutput("core_d", core_d, 128'(v.d));
        core_g = v.g;
        for (int t = 0; t < v.fiDelay; t++) begin
            tick();
        end
        checkOutput("no_early_result", 128'(out_valid), 128'(1'b0));
        checkOutput("core_en_busy", 128'(core_en), 128'(1'b1));
        core_fi = v.fiMask;
        tick();
        core_fi = 4'd0;
        checkOutput("core_en_drop", 128'(core_en), 128'(1'b0));
        drainExpect(v.nJobs, v.g, 4'b0000, -1);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 32'd0;
        in_b = 32'd0;
        in_c = 32'd0;
        in_d = 32'd0;
        out_ready = 1'b0;
        core_g = 128'd0;
        core_fi = 4'd0;

        // Row 0: full batch with a = 1.0, 2.0, 3.0, 4.0
        vecs[0].nJobs = 4; vecs[0].fiDelay = 5; vecs[0].expWait = 0; vecs[0].fiMask = 4'hF;
        vecs[0].a = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        vecs[0].b = {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000};
        vecs[0].c = {32'h11110004, 32'h11110003, 32'h11110002, 32'h11110001};
        vecs[0].d = {32'h22220004, 32'h22220003, 32'h22220002, 32'h22220001};
        vecs[0].g = {32'hC0000004, 32'hB0000003, 32'hA0000002, 32'h90000001};
        // Row 1: partial batch of 2, finish already high on first BUSY cycle
        vecs[1].nJobs = 2; vecs[1].fiDelay = 1; vecs[1].expWait = 16; vecs[1].fiMask = 4'b0011;
        vecs[1].a = {32'h0, 32'h0, 32'h40A00000, 32'h40C00000};
        vecs[1].b = {32'h0, 32'h0, 32'h33330002, 32'h33330001};
        vecs[1].c = {32'h0, 32'h0, 32'h44440002, 32'h44440001};
        vecs[1].d = {32'h0, 32'h0, 32'h55550002, 32'h55550001};
        vecs[1].g = {32'h0, 32'h0, 32'h12345678, 32'h87654321};
        // Row 2: partial batch of 3
        vecs[2].nJobs = 3; vecs[2].fiDelay = 2; vecs[2].expWait = 16; vecs[2].fiMask = 4'b0111;
        vecs[2].a = {32'h0, 32'hA0A0A0A3, 32'hA0A0A0A2, 32'hA0A0A0A1};
        vecs[2].b = {32'h0, 32'hB0B0B0B3, 32'hB0B0B0B2, 32'hB0B0B0B1};
        vecs[2].c = {32'h0, 32'hC0C0C0C3, 32'hC0C0C0C2, 32'hC0C0C0C1};
        vecs[2].d = {32'h0, 32'hD0D0D0D3, 32'hD0D0D0D2, 32'hD0D0D0D1};
        vecs[2].g = {32'h0, 32'h0F0F0F03, 32'h0F0F0F02, 32'h0F0F0F01};
        // Row 3: single job
        vecs[3].nJobs = 1; vecs[3].fiDelay = 3; vecs[3].expWait = 16; vecs[3].fiMask = 4'b0001;
        vecs[3].a = {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF};
        vecs[3].b = {32'h0, 32'h0, 32'h0, 32'h80000000};
        vecs[3].c = {32'h0, 32'h0, 32'h0, 32'h00000001};
        vecs[3].d = {32'h0, 32'h0, 32'h0, 32'h7FFFFFFF};
        vecs[3].g = {32'h0, 32'h0, 32'h0, 32'h5A5A5A5A};

        tick();
        tick();
        checkOutput("reset_in_ready", 128'(in_ready), 128'(1'b1));
        checkOutput("reset_out_valid", 128'(out_valid), 128'(1'b0));
        checkOutput("reset_core_en", 128'(core_en), 128'(1'b0));
        checkOutput("reset_busy", 128'(busy), 128'(1'b0));
        checkOutput("reset_out_g", 128'({out_err, out_lane, out_g}), 128'd0);
        checkOutput("reset_core_a", core_a, 128'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            runBatch(i);
            tick();
        end

        // Staggered finish pulses; results latch only after the last lane,
        // then core_g is scrambled and lane 1 is stalled for 10 cycles.
        core_g = vecs[0].g;
        applyStimulus(vecs[0]);
        for (int t = 1; t <= 12; t++) begin
            core_fi = (t == 3)  ? 4'b0001 :
                      (t == 7)  ? 4'b0100 :
                      (t == 9)  ? 4'b0010 :
                      (t == 12) ? 4'b1000 : 4'b0000;
            tick();
            if (t == 11) begin
                checkOutput("stagger_not_done", 128'(out_valid), 128'(1'b0));
                checkOutput("stagger_core_en", 128'(core_en), 128'(1'b1));
            end
        end
        core_fi = 4'd0;
        core_g = {4{32'hDEADBEEF}};
        drainExpect(4, vecs[0].g, 4'b0000, 1);
        tick();

        // Reset mid-BUSY abandons the batch.
        applyStimulus(vecs[0]);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_busy_core_en", 128'(core_en), 128'(1'b0));
        checkOutput("rst_busy_out_valid", 128'(out_valid), 128'(1'b0));
        checkOutput("rst_busy_in_ready", 128'(in_ready), 128'(1'b1));
        core_fi = 4'hF;
        tick();
        core_fi = 4'd0;
        checkOutput("fi_ignored_idle", 128'(out_valid), 128'(1'b0));
        runBatch(0);
        tick();

`ifdef QSCHED_WATCHDOG_EN
        // Lane 3 never finishes: abort after 8 BUSY cycles.
        begin
            logic [3:0][31:0] wdExp;
            wdExp = {32'h0, vecs[0].g[2], vecs[0].g[1], vecs[0].g[0]};
            core_g = vecs[0].g;
            applyStimulus(vecs[0]);
            tick();
            core_fi = 4'b0111;
            tick();
            core_fi = 4'd0;
            for (int t = 0; t < 6; t++) begin
                tick();
            end
            checkOutput("wd_not_yet", 128'(out_valid), 128'(1'b0));
            tick();
            checkOutput("wd_core_en", 128'(core_en), 128'(1'b0));
            drainExpect(4, wdExp, 4'b1000, -1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
